// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, ALU op encodings and forward-select encodings for the ID/EX operand stage.
package id_ex_operand_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  // A bubble parks the ALU on the all-zero op so downstream sees a harmless encoding.
  localparam logic [3:0] ALU_BUBBLE = 4'b0000;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-to-EX bundle: decoded instruction fields in, EX-slot operands and control out.
interface id_ex_operand_stage_if
  import id_ex_operand_stage_pkg::*;
#(
  parameter int N  = DATA_W,
  parameter int RW = ADDR_W
);

  logic          id_valid;
  logic [N-1:0]  id_rs1_data;
  logic [N-1:0]  id_rs2_data;
  logic [N-1:0]  id_imm;
  logic [RW-1:0] id_rs1_addr;
  logic [RW-1:0] id_rs2_addr;
  logic [RW-1:0] id_rd_addr;
  logic [3:0]    id_alu_sel;
  logic          id_alu_src_imm;
  logic          id_mem_read;
  logic          id_reg_write;

  logic          ex_valid;
  logic [N-1:0]  Alu1stSource;
  logic [N-1:0]  Alu2ndSource;
  logic [3:0]    ALUSelection;
  logic [N-1:0]  ex_store_data;
  logic [RW-1:0] ex_rd_addr;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          load_use_hazard;

  modport master (
    output id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr,
           id_rd_addr, id_alu_sel, id_alu_src_imm, id_mem_read, id_reg_write,
    input  ex_valid, Alu1stSource, Alu2ndSource, ALUSelection, ex_store_data,
           ex_rd_addr, ex_reg_write, ex_mem_read, load_use_hazard
  );

  modport slave (
    input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr,
           id_rd_addr, id_alu_sel, id_alu_src_imm, id_mem_read, id_reg_write,
    output ex_valid, Alu1stSource, Alu2ndSource, ALUSelection, ex_store_data,
           ex_rd_addr, ex_reg_write, ex_mem_read, load_use_hazard
  );

endinterface

// File: rtl/id_ex_operand_stage_forwarding_unit.sv
// Picks the freshest producer for each EX source register; EX/MEM beats MEM/WB, x0 never forwards.
module forwarding_unit
  import id_ex_operand_stage_pkg::*;
#(
  parameter int RW = ADDR_W
) (
  input  logic [RW-1:0] rs1_addr,
  input  logic [RW-1:0] rs2_addr,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd_addr,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd_addr,
  output fwd_sel_e      rs1_sel,
  output fwd_sel_e      rs2_sel
);

  logic exmem_hit_rs1, exmem_hit_rs2, memwb_hit_rs1, memwb_hit_rs2;

  assign exmem_hit_rs1 = exmem_reg_write && (exmem_rd_addr == rs1_addr) && (rs1_addr != '0);
  assign exmem_hit_rs2 = exmem_reg_write && (exmem_rd_addr == rs2_addr) && (rs2_addr != '0);
  assign memwb_hit_rs1 = memwb_reg_write && (memwb_rd_addr == rs1_addr) && (rs1_addr != '0);
  assign memwb_hit_rs2 = memwb_reg_write && (memwb_rd_addr == rs2_addr) && (rs2_addr != '0);

  always_comb begin
    rs1_sel = FWD_RF;
    rs2_sel = FWD_RF;
    if (exmem_hit_rs1)      rs1_sel = FWD_EXMEM;
    else if (memwb_hit_rs1) rs1_sel = FWD_MEMWB;
    if (exmem_hit_rs2)      rs2_sel = FWD_EXMEM;
    else if (memwb_hit_rs2) rs2_sel = FWD_MEMWB;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with forwarded ALU operand selection and load-use bubble insertion.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int N  = DATA_W,
  parameter int RW = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exmem_reg_write,
  input  logic [RW-1:0]         exmem_rd_addr,
  input  logic [N-1:0]          exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [RW-1:0]         memwb_rd_addr,
  input  logic [N-1:0]          memwb_result,
  id_ex_operand_stage_if.slave  bus
);

  logic          ex_valid_q;
  logic [RW-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [N-1:0]  rs1_data_q, rs2_data_q, imm_q;
  logic [3:0]    alu_sel_q;
  logic          alu_src_imm_q, mem_read_q, reg_write_q;

  logic          hazard;
  fwd_sel_e      rs1_sel, rs2_sel;
  logic [N-1:0]  rs1_fwd, rs2_fwd;

  // Conservative: any match against rs1/rs2 stalls, even when rs2 is replaced by the immediate.
  assign hazard = ex_valid_q && mem_read_q && (rd_addr_q != '0) && bus.id_valid &&
                  ((rd_addr_q == bus.id_rs1_addr) || (rd_addr_q == bus.id_rs2_addr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q    <= 1'b0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rd_addr_q     <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      alu_sel_q     <= ALU_BUBBLE;
      alu_src_imm_q <= 1'b0;
      mem_read_q    <= 1'b0;
      reg_write_q   <= 1'b0;
    end else if (flush || (!stall && hazard)) begin
      ex_valid_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      alu_sel_q   <= ALU_BUBBLE;
    end else if (!stall) begin
      ex_valid_q    <= bus.id_valid;
      rs1_addr_q    <= bus.id_rs1_addr;
      rs2_addr_q    <= bus.id_rs2_addr;
      rd_addr_q     <= bus.id_rd_addr;
      rs1_data_q    <= bus.id_rs1_data;
      rs2_data_q    <= bus.id_rs2_data;
      imm_q         <= bus.id_imm;
      alu_sel_q     <= bus.id_alu_sel;
      alu_src_imm_q <= bus.id_alu_src_imm;
      mem_read_q    <= bus.id_mem_read && bus.id_valid;
      reg_write_q   <= bus.id_reg_write && bus.id_valid;
    end
  end

  forwarding_unit #(.RW(RW)) u_fwd (
    .rs1_addr        (rs1_addr_q),
    .rs2_addr        (rs2_addr_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .rs1_sel         (rs1_sel),
    .rs2_sel         (rs2_sel)
  );

  always_comb begin
    rs1_fwd = rs1_data_q;
    rs2_fwd = rs2_data_q;
    case (rs1_sel)
      FWD_EXMEM: rs1_fwd = exmem_result;
      FWD_MEMWB: rs1_fwd = memwb_result;
      default:   rs1_fwd = rs1_data_q;
    endcase
    case (rs2_sel)
      FWD_EXMEM: rs2_fwd = exmem_result;
      FWD_MEMWB: rs2_fwd = memwb_result;
      default:   rs2_fwd = rs2_data_q;
    endcase
  end

  assign bus.ex_valid        = ex_valid_q;
  assign bus.Alu1stSource    = rs1_fwd;
  assign bus.Alu2ndSource    = alu_src_imm_q ? imm_q : rs2_fwd;
  assign bus.ALUSelection    = alu_sel_q;
  assign bus.ex_store_data   = rs2_fwd;
  assign bus.ex_rd_addr      = rd_addr_q;
  assign bus.ex_reg_write    = reg_write_q && ex_valid_q;
  assign bus.ex_mem_read     = mem_read_q && ex_valid_q;
  assign bus.load_use_hazard = hazard;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed hazard/forwarding cases plus a random run.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  typedef struct {
    logic        id_valid;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  sel;
    logic        src_imm, mem_read, reg_write, stall, flush;
    logic        exmem_we;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_res;
    logic        memwb_we;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_res;
  } stim_t;

  typedef struct {
    logic        valid, rw, mr;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic [31:0] alu1, alu2, store;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_result, memwb_result;

  int check_count = 0;
  int pass_count  = 0;
  exp_t exp_q[$];

  // Reference copy of the EX-slot register contents.
  logic        m_valid, m_rw, m_mr, m_src_imm;
  logic [4:0]  m_rs1a, m_rs2a, m_rd;
  logic [31:0] m_rs1d, m_rs2d, m_imm;
  logic [3:0]  m_sel;

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.N(32), .RW(5)) bus ();

  id_ex_operand_stage #(.N(32), .RW(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .bus             (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic [31:0] fwd_model(input logic [4:0] a, input logic [31:0] rf, input stim_t s);
    if (s.exmem_we && s.exmem_rd == a && a != 5'd0) return s.exmem_res;
    if (s.memwb_we && s.memwb_rd == a && a != 5'd0) return s.memwb_res;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_src_imm = 0;
    m_rs1a = 0; m_rs2a = 0; m_rd = 0;
    m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_sel = 4'b0000;
    exp_q.delete();
  endtask

  task automatic driveInputs(input stim_t s);
    bus.id_valid       = s.id_valid;
    bus.id_rs1_data    = s.rs1_data;
    bus.id_rs2_data    = s.rs2_data;
    bus.id_imm         = s.imm;
    bus.id_rs1_addr    = s.rs1;
    bus.id_rs2_addr    = s.rs2;
    bus.id_rd_addr     = s.rd;
    bus.id_alu_sel     = s.sel;
    bus.id_alu_src_imm = s.src_imm;
    bus.id_mem_read    = s.mem_read;
    bus.id_reg_write   = s.reg_write;
    stall              = s.stall;
    flush              = s.flush;
    exmem_reg_write    = s.exmem_we;
    exmem_rd_addr      = s.exmem_rd;
    exmem_result       = s.exmem_res;
    memwb_reg_write    = s.memwb_we;
    memwb_rd_addr      = s.memwb_rd;
    memwb_result       = s.memwb_res;
  endtask

  // One cycle: drive at negedge, predict and queue the EX view, compare just after the posedge.
  task automatic applyStimulus(input stim_t s, output logic luh_seen);
    exp_t        e;
    logic        hz;
    logic [31:0] rs2f;
    @(negedge clk);
    driveInputs(s);
    #1;
    hz = m_valid && m_mr && (m_rd != 5'd0) && s.id_valid && ((m_rd == s.rs1) || (m_rd == s.rs2));
    luh_seen = bus.load_use_hazard;
    checkOutput("load_use_hazard", 32'(bus.load_use_hazard), 32'(hz));
    if (s.flush || (!s.stall && hz)) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_sel = 4'b0000;
    end else if (!s.stall) begin
      m_valid = s.id_valid; m_rs1a = s.rs1; m_rs2a = s.rs2; m_rd = s.rd;
      m_rs1d = s.rs1_data; m_rs2d = s.rs2_data; m_imm = s.imm; m_sel = s.sel;
      m_src_imm = s.src_imm; m_mr = s.mem_read && s.id_valid; m_rw = s.reg_write && s.id_valid;
    end
    e.valid = m_valid;
    e.rw    = m_valid && m_rw;
    e.mr    = m_valid && m_mr;
    e.sel   = m_sel;
    e.rd    = m_rd;
    e.alu1  = fwd_model(m_rs1a, m_rs1d, s);
    rs2f    = fwd_model(m_rs2a, m_rs2d, s);
    e.alu2  = m_src_imm ? m_imm : rs2f;
    e.store = rs2f;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checkOutput("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
    checkOutput("ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
    checkOutput("ex_mem_read", 32'(bus.ex_mem_read), 32'(e.mr));
    checkOutput("ALUSelection", 32'(bus.ALUSelection), 32'(e.sel));
    if (e.valid) begin
      checkOutput("ex_rd_addr", 32'(bus.ex_rd_addr), 32'(e.rd));
      checkOutput("Alu1stSource", bus.Alu1stSource, e.alu1);
      checkOutput("Alu2ndSource", bus.Alu2ndSource, e.alu2);
      checkOutput("ex_store_data", bus.ex_store_data, e.store);
    end
  endtask

  initial begin
    stim_t s;
    logic  luh;

    driveInputs(idle());
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    checkOutput("rst_alu_sel", 32'(bus.ALUSelection), 32'd0);
    checkOutput("rst_alu1", bus.Alu1stSource, 32'd0);
    checkOutput("rst_alu2", bus.Alu2ndSource, 32'd0);
    checkOutput("rst_luh", 32'(bus.load_use_hazard), 32'd0);
    rst = 1'b1;

    // EX/MEM forward to rs1, then EX/MEM priority and MEM/WB fallback while stalled.
    s = idle();
    s.id_valid = 1; s.rs1 = 5; s.rs1_data = 32'h10; s.rs2 = 6; s.rs2_data = 32'h20;
    s.rd = 8; s.sel = ALU_ADD; s.reg_write = 1;
    s.exmem_we = 1; s.exmem_rd = 5; s.exmem_res = 32'h99;
    applyStimulus(s, luh);
    checkOutput("exmem_fwd", bus.Alu1stSource, 32'h99);
    s.stall = 1; s.memwb_we = 1; s.memwb_rd = 5; s.memwb_res = 32'h77;
    applyStimulus(s, luh);
    checkOutput("exmem_priority", bus.Alu1stSource, 32'h99);
    s.exmem_we = 0;
    applyStimulus(s, luh);
    checkOutput("memwb_fwd", bus.Alu1stSource, 32'h77);

    // x0 is never forwarded.
    s = idle();
    s.id_valid = 1; s.rs1 = 1; s.rs1_data = 32'h3; s.rs2 = 0; s.rs2_data = 32'h0;
    s.rd = 2; s.sel = ALU_OR; s.reg_write = 1;
    s.exmem_we = 1; s.exmem_rd = 0; s.exmem_res = 32'hFF;
    s.memwb_we = 1; s.memwb_rd = 0; s.memwb_res = 32'hEE;
    applyStimulus(s, luh);
    checkOutput("x0_guard_alu2", bus.Alu2ndSource, 32'h0);
    checkOutput("x0_guard_store", bus.ex_store_data, 32'h0);

    // Immediate replaces operand 2 but store data still carries forwarded rs2.
    s = idle();
    s.id_valid = 1; s.rs1 = 1; s.rs1_data = 32'h8; s.rs2 = 9; s.rs2_data = 32'h1;
    s.imm = 32'hFFFF_FFFC; s.src_imm = 1; s.sel = ALU_ADD;
    s.memwb_we = 1; s.memwb_rd = 9; s.memwb_res = 32'h5;
    applyStimulus(s, luh);
    checkOutput("imm_alu2", bus.Alu2ndSource, 32'hFFFF_FFFC);
    checkOutput("imm_store", bus.ex_store_data, 32'h5);

    // Load-use: lw x7 followed by add using x7.
    s = idle();
    s.id_valid = 1; s.rs1 = 2; s.rs1_data = 32'h100; s.imm = 32'h4; s.src_imm = 1;
    s.rd = 7; s.mem_read = 1; s.reg_write = 1; s.sel = ALU_ADD;
    applyStimulus(s, luh);
    checkOutput("lw_mem_read", 32'(bus.ex_mem_read), 32'd1);
    s = idle();
    s.id_valid = 1; s.rs1 = 7; s.rs1_data = 32'hDEAD; s.rs2 = 3; s.rs2_data = 32'h3;
    s.rd = 9; s.reg_write = 1; s.sel = ALU_ADD;
    applyStimulus(s, luh);
    checkOutput("lu_hazard_set", 32'(luh), 32'd1);
    checkOutput("lu_bubble", 32'(bus.ex_valid), 32'd0);
    s.memwb_we = 1; s.memwb_rd = 7; s.memwb_res = 32'h1234;
    applyStimulus(s, luh);
    checkOutput("lu_hazard_clear", 32'(luh), 32'd0);
    checkOutput("lu_replay_valid", 32'(bus.ex_valid), 32'd1);
    checkOutput("lu_replay_fwd", bus.Alu1stSource, 32'h1234);

    // Stall holds the slot for three cycles; flush beats stall.
    s = idle();
    s.id_valid = 1; s.rs1 = 3; s.rs1_data = 32'h30; s.rs2 = 4; s.rs2_data = 32'h40;
    s.rd = 10; s.reg_write = 1; s.sel = ALU_SUB;
    applyStimulus(s, luh);
    for (int i = 0; i < 3; i++) begin
      s.stall = 1; s.rs1_data = $urandom; s.rs2_data = $urandom; s.sel = ALU_AND;
      applyStimulus(s, luh);
      checkOutput("stall_alu1", bus.Alu1stSource, 32'h30);
      checkOutput("stall_alu2", bus.Alu2ndSource, 32'h40);
      checkOutput("stall_sel", 32'(bus.ALUSelection), 32'(ALU_SUB));
      checkOutput("stall_valid", 32'(bus.ex_valid), 32'd1);
    end
    s.flush = 1;
    applyStimulus(s, luh);
    checkOutput("flush_over_stall", 32'(bus.ex_valid), 32'd0);

    // Asynchronous reset while the slot is valid.
    s = idle();
    s.id_valid = 1; s.rs1 = 5; s.rs1_data = 32'h55; s.rs2 = 6; s.rs2_data = 32'h66;
    s.rd = 4; s.sel = ALU_OR; s.reg_write = 1;
    s.exmem_we = 1; s.exmem_rd = 5; s.exmem_res = 32'h99;
    applyStimulus(s, luh);
    checkOutput("pre_reset_valid", 32'(bus.ex_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_ex_valid", 32'(bus.ex_valid), 32'd0);
    checkOutput("midrst_alu_sel", 32'(bus.ALUSelection), 32'd0);
    checkOutput("midrst_alu1", bus.Alu1stSource, 32'd0);
    checkOutput("midrst_alu2", bus.Alu2ndSource, 32'd0);
    checkOutput("midrst_store", bus.ex_store_data, 32'd0);
    checkOutput("midrst_luh", 32'(bus.load_use_hazard), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic on a small register window so hazards and forwards collide often.
    for (int i = 0; i < 80; i++) begin
      s = idle();
      s.id_valid  = ($urandom_range(0, 7) != 0);
      s.rs1       = 5'($urandom_range(0, 3));
      s.rs2       = 5'($urandom_range(0, 3));
      s.rd        = 5'($urandom_range(0, 3));
      s.rs1_data  = $urandom;
      s.rs2_data  = $urandom;
      s.imm       = $urandom;
      s.sel       = 4'($urandom_range(0, 15));
      s.src_imm   = 1'($urandom_range(0, 1));
      s.mem_read  = ($urandom_range(0, 2) == 0);
      s.reg_write = 1'($urandom_range(0, 1));
      s.stall     = ($urandom_range(0, 5) == 0);
      s.flush     = ($urandom_range(0, 9) == 0);
      s.exmem_we  = 1'($urandom_range(0, 1));
      s.exmem_rd  = 5'($urandom_range(0, 3));
      s.exmem_res = $urandom;
      s.memwb_we  = 1'($urandom_range(0, 1));
      s.memwb_rd  = 5'($urandom_range(0, 3));
      s.memwb_res = $urandom;
      applyStimulus(s, luh);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
